// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand sequencer and the downstream MAC/accumulator stage.
// Default operand width, delay-line depth and the sequencer state encoding live here.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Stream, coefficient-write and operand-issue bundle between the sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the upstream/MAC side.
interface mac_operand_sequencer_if #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ADDR_W = mac_pkg::ADDR_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_wdata;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_first;
  logic              op_last;
  logic              busy;

  modport master (
    output s_valid, s_data, coef_we, coef_addr, coef_wdata, op_ready,
    input  s_ready, op_valid, op_a, op_b, op_first, op_last, busy
  );

  modport slave (
    input  s_valid, s_data, coef_we, coef_addr, coef_wdata, op_ready,
    output s_ready, op_valid, op_a, op_b, op_first, op_last, busy
  );

endinterface

// File: rtl/mac_tap_regfile.sv
// Small TAPS x DATA_W register file: synchronous write, asynchronous read, cleared by rst.
// Used both as the sample delay line and as the coefficient store.
module mac_tap_regfile #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds the MAC with TAPS (sample, coefficient) pairs per accepted sample, newest sample first,
// tagging the first and last pair so the MAC can clear and dump its accumulator.
module mac_operand_sequencer #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int TAPS   = mac_pkg::TAPS,
  parameter int ADDR_W = mac_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  mac_operand_sequencer_if.slave  bus
);

  import mac_pkg::*;

  localparam logic [ADDR_W-1:0] PRE_LAST_TAP = ADDR_W'(TAPS - 2);

  seq_state_e        state;
  logic [ADDR_W-1:0] tap;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] dline_raddr;
  logic              accept;
  logic              op_fire;
  logic              coef_wr;

  assign bus.s_ready = (state == IDLE) && !rst;
  assign accept      = bus.s_valid && bus.s_ready;
  assign op_fire     = bus.op_valid && bus.op_ready;
  // Coefficients are frozen while a sample is being issued so its pairs share one coefficient set.
  assign coef_wr     = bus.coef_we && (state == IDLE);
  assign dline_raddr = base - tap;

  mac_tap_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (TAPS),
    .ADDR_W (ADDR_W)
  ) u_dline (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (bus.s_data),
    .raddr (dline_raddr),
    .rdata (bus.op_a)
  );

  mac_tap_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (TAPS),
    .ADDR_W (ADDR_W)
  ) u_coef (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_wr),
    .waddr (bus.coef_addr),
    .wdata (bus.coef_wdata),
    .raddr (tap),
    .rdata (bus.op_b)
  );

  // Tags and valid are registered alongside tap so they stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tap          <= '0;
      wr_ptr       <= '0;
      base         <= '0;
      bus.op_valid <= 1'b0;
      bus.op_first <= 1'b0;
      bus.op_last  <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= ISSUE;
            base         <= wr_ptr;
            tap          <= '0;
            bus.op_valid <= 1'b1;
            bus.op_first <= 1'b1;
            bus.op_last  <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (op_fire) begin
            if (bus.op_last) begin
              state        <= IDLE;
              tap          <= '0;
              wr_ptr       <= wr_ptr + 1'b1;
              bus.op_valid <= 1'b0;
              bus.op_first <= 1'b0;
              bus.op_last  <= 1'b0;
              bus.busy     <= 1'b0;
            end else begin
              tap          <= tap + 1'b1;
              bus.op_first <= 1'b0;
              bus.op_last  <= (tap == PRE_LAST_TAP);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
